store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 141 ++++++++++++++
 tb/tb_store_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: in-order FIFO of pending stores that drains to data memory whenever the load path is idle.
// Optional STORE_BUF_ALIGN_CHK_EN drops misaligned sh/sw stores and pulses st_err for one cycle.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          st_valid,
  output logic                          st_ready,
  input  logic [ADDR_WIDTH-1:0]         st_addr,
  input  logic [DATA_WIDTH-1:0]         st_data,
  input  logic [2:0]                    st_funct3,
  input  logic                          ld_req,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  output logic                          ld_stall,
  output logic                          mem_wr_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  output logic [2:0]                    mem_funct3,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          st_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [2:0]            f3_mem   [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic             full_s;
  logic             push_hs_s;
  logic             push_s;
  logic             pop_s;
  logic             misalign_s;
  logic             ld_conflict_s;
  logic [DEPTH-1:0] match_s;
  logic             unused_ld_lo_s;

  // Only the word address takes part in the load/store overlap check.
  assign unused_ld_lo_s = ^ld_addr[1:0];

`ifdef STORE_BUF_ALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001:  is_misaligned = a[0];
      3'b010:  is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  logic st_err_q, st_err_d;

  assign misalign_s = is_misaligned(st_funct3, st_addr[1:0]);
  assign st_err_d   = push_hs_s & misalign_s;
  assign st_err     = st_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_err_q <= 1'b0;
    end else begin
      st_err_q <= st_err_d;
    end
  end
`else
  assign misalign_s = 1'b0;
  assign st_err     = 1'b0;
`endif

  always_comb begin
    full_s    = (count_q == CW'(DEPTH));
    empty     = (count_q == {CW{1'b0}});
    st_ready  = ~full_s;
    count     = count_q;
    push_hs_s = st_valid & ~full_s;
    push_s    = push_hs_s & ~misalign_s;
    match_s   = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_q[i] & (addr_mem[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]);
    end
    ld_conflict_s = ld_req & (|match_s);
    ld_stall      = ld_conflict_s;
    // A load owns the memory port unless it must wait for a matching store to drain.
    mem_wr_en     = ~empty & (~ld_req | ld_conflict_s);
    pop_s         = mem_wr_en;
    mem_addr      = addr_mem[head_q];
    mem_wr_data   = data_mem[head_q];
    mem_funct3    = f3_mem[head_q];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (pop_s) begin
      head_d          = head_q + PW'(1);
      valid_d[head_q] = 1'b0;
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d          = tail_q + PW'(1);
      valid_d[tail_q] = 1'b1;
    end else begin
      tail_d = tail_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      valid_q <= {DEPTH{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by valid_q/count_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem[tail_q] <= st_addr;
      data_mem[tail_q] <= st_data;
      f3_mem[tail_q]   <= st_funct3;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (DEPTH=4) plus hand-written wrap, reset and alignment sequences.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_funct3;
  logic [2:0]  count;
  logic        empty;
  logic        st_err;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_funct3(st_funct3), .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_funct3(mem_funct3), .count(count), .empty(empty), .st_err(st_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [2:0]  sf;
    logic        ld;
    logic [31:0] la;
    logic        e_ready;
    logic        e_wr;
    logic        e_stall;
    logic [2:0]  e_cnt;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_f3;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic [2:0] sf,
                              logic ld, logic [31:0] la, logic er, logic ew, logic es,
                              logic [2:0] ec, logic [31:0] ea, logic [31:0] ed, logic [2:0] ef);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.sf = sf; v.ld = ld; v.la = la;
    v.e_ready = er; v.e_wr = ew; v.e_stall = es; v.e_cnt = ec;
    v.e_addr = ea; v.e_data = ed; v.e_f3 = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [2:0] sf, input logic ld, input logic [31:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf; ld_req = ld; ld_addr = la;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    int          sent;
    int          mcnt;
    bit          done;
    logic        exp_wr;

    // sw = 3'b010, sh = 3'b001, sb = 3'b000
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 0,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 1, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h40, 32'h1, 3'b010, 1, 32'h100,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h44, 32'h2, 3'b010, 1, 32'h100,      1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h48, 32'h3, 3'b010, 1, 32'h100,      1, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4C, 32'h4, 3'b010, 1, 32'h100,      1, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 32'h50, 32'h5, 3'b010, 1, 32'h100,      0, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          0, 1, 0, 4, 32'h40, 32'h1, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 1, 0, 3, 32'h44, 32'h2, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 1, 0, 2, 32'h48, 32'h3, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 1, 0, 1, 32'h4C, 32'h4, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h23, 32'hAB, 3'b000, 0, 0,           1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h20,                     1, 1, 1, 1, 32'h23, 32'hAB, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h20,                     1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h23, 32'hCD, 3'b000, 0, 0,           1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h24,                     1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h24,                     1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 1, 0, 1, 32'h23, 32'hCD, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h30, 32'h11, 3'b010, 1, 32'h300,     1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h31, 32'h22, 3'b000, 1, 32'h300,     1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h32,                     1, 1, 1, 2, 32'h30, 32'h11, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h32,                     1, 1, 1, 1, 32'h31, 32'h22, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h32,                     1, 0, 0, 0, 0, 0, 0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_count", count, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_stall", ld_stall, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_st_err", st_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].sf, vecs[i].ld, vecs[i].la);
      #1;
      chk($sformatf("v%0d_ready", i), st_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_wr_en", i), mem_wr_en, vecs[i].e_wr);
      chk($sformatf("v%0d_stall", i), ld_stall, vecs[i].e_stall);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("v%0d_empty", i), empty, (vecs[i].e_cnt == 3'd0));
      chk($sformatf("v%0d_st_err", i), st_err, 0);
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_data", i), mem_wr_data, vecs[i].e_data);
        chk($sformatf("v%0d_f3", i), mem_funct3, vecs[i].e_f3);
      end
    end

    // Full buffer, rejected push, then push+pop streaming across pointer wrap (10 stores).
    sent = 0;
    mcnt = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      drive((sent < 10), 32'h200 + 32'(sent * 4), 32'hA000 + 32'(sent), 3'b010, (c < 4), 32'h1000);
      #1;
      exp_wr = (mcnt != 0) && !ld_req;
      chk($sformatf("wrap%0d_ready", c), st_ready, (mcnt != 4));
      chk($sformatf("wrap%0d_count", c), count, mcnt);
      chk($sformatf("wrap%0d_wr_en", c), mem_wr_en, exp_wr);
      if (exp_wr) begin
        chk($sformatf("wrap%0d_addr", c), mem_addr, qa[0]);
        chk($sformatf("wrap%0d_data", c), mem_wr_data, qd[0]);
      end
      if (st_valid && mcnt != 4) begin
        qa.push_back(st_addr);
        qd.push_back(st_data);
        sent++;
        mcnt++;
      end
      if (exp_wr) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        mcnt--;
      end
      if (sent == 10 && mcnt == 0) done = 1'b1;
    end
    chk("wrap_completed", done, 1);
    st_valid = 1'b0;

    // Reset asserted mid-drain with three entries pending.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 32'h80 + 32'(k * 4), 32'hB0 + 32'(k), 3'b010, 1, 32'h1000);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("middrain_count", count, 3);
    chk("middrain_wr_en", mem_wr_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", mem_wr_en, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", st_ready, 1);
    chk("arst_empty", empty, 1);
    chk("arst_stall", ld_stall, 0);
    @(negedge clk);
    #1;
    chk("arst_hold_wr_en", mem_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h60, 32'h600D, 3'b010, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_count", count, 1);
    chk("post_rst_wr_en", mem_wr_en, 1);
    chk("post_rst_addr", mem_addr, 32'h60);
    chk("post_rst_data", mem_wr_data, 32'h600D);
    @(negedge clk);
    #1;
    chk("post_rst_drained", count, 0);
    chk("post_rst_no_wr", mem_wr_en, 0);

    // Misaligned sw to 0x12.
    @(negedge clk);
    drive(1, 32'h12, 32'h77, 3'b010, 0, 0);
    #1;
    chk("mis_ready", st_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
`ifdef STORE_BUF_ALIGN_CHK_EN
    chk("mis_st_err", st_err, 1);
    chk("mis_count", count, 0);
    chk("mis_wr_en", mem_wr_en, 0);
`else
    chk("mis_st_err", st_err, 0);
    chk("mis_count", count, 1);
    chk("mis_wr_en", mem_wr_en, 1);
    chk("mis_addr", mem_addr, 32'h12);
`endif
    @(negedge clk);
    #1;
    chk("mis_st_err_clear", st_err, 0);
    chk("mis_final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
